// File: rtl/ser_piso_stream_pkg.sv
// Shared definitions for the parallel-in/serial-out word serializer:
// FSM state encodings and the bit-count width helper.
package ser_piso_stream_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'b00;
  localparam state_t S_SHIFT = 2'b01;

  // Bits needed to hold a count of WIDTH-1 down to 0.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_piso_stream_if.sv
// Word-load handshake plus serial-stream signals of ser_piso_stream.
// master = word source / stream consumer, slave = serializer.
interface ser_piso_stream_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             hold;
    logic             bit_out;
    logic             bit_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output load_valid, load_data, hold,
        input  load_ready, bit_out, bit_valid, word_done, busy
    );

    modport slave (
        input  load_valid, load_data, hold,
        output load_ready, bit_out, bit_valid, word_done, busy
    );
endinterface

// File: rtl/ser_piso_stream.sv
// Word serializer: accepts WIDTH-bit words on a valid/ready handshake and emits
// them one bit per clock; a one-deep buffer keeps back-to-back words gapless.
module ser_piso_stream
    import ser_piso_stream_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    ser_piso_stream_if.slave bus
);

    localparam int unsigned          CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   buf_q, buf_d;
    logic               buf_full_q, buf_full_d;

    logic               in_shift;
    logic               advance;
    logic               last_bit;
    logic               accept;
    logic [WIDTH-1:0]   shreg_shifted;

    assign in_shift = (state_q == S_SHIFT);
    assign advance  = in_shift && !bus.hold;
    assign last_bit = advance && (cnt_q == '0);
    assign accept   = bus.load_valid && !buf_full_q;

    assign bus.load_ready = !buf_full_q;
    assign bus.bit_valid  = advance;
    assign bus.word_done  = last_bit;
    assign bus.busy       = in_shift | buf_full_q;
    assign bus.bit_out    = in_shift & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

    always_comb begin
        if (MSB_FIRST) shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        else           shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shreg_d = bus.load_data;
                    cnt_d   = CNT_LAST;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (last_bit) begin
                    // Buffer wins over bypass; load_ready is low whenever it is full.
                    if (buf_full_q) begin
                        shreg_d    = buf_q;
                        cnt_d      = CNT_LAST;
                        buf_full_d = 1'b0;
                        buf_d      = '0;
                    end else if (accept) begin
                        shreg_d = bus.load_data;
                        cnt_d   = CNT_LAST;
                    end else begin
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    if (advance) begin
                        shreg_d = shreg_shifted;
                        cnt_d   = cnt_q - 1'b1;
                    end
                    if (accept) begin
                        buf_d      = bus.load_data;
                        buf_full_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                shreg_d    = '0;
                cnt_d      = '0;
                buf_d      = '0;
                buf_full_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

endmodule

// File: tb/tb_ser_piso_stream.sv
// Bench for ser_piso_stream: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a word-queue reference model.
module tb_ser_piso_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv;
    logic       hd;
    logic [7:0] ld;

    always #5 clk = ~clk;

    ser_piso_stream_if #(.WIDTH(8)) bus_m ();
    ser_piso_stream_if #(.WIDTH(8)) bus_l ();

    assign bus_m.load_valid = lv;
    assign bus_m.load_data  = ld;
    assign bus_m.hold       = hd;
    assign bus_l.load_valid = lv;
    assign bus_l.load_data  = ld;
    assign bus_l.hold       = hd;

    ser_piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    ser_piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    int total = 0;
    int bad   = 0;

    // Reference model: words not yet fully emitted, and bits already sent of the head word.
    logic [7:0] wq[$];
    int         pos = 0;
    bit         acc;

    logic [63:0] col_m, col_l;
    int          ncol, nbusy, done_at, cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        col_m = '0; col_l = '0; ncol = 0; nbusy = 0; cyc = 0; done_at = -1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_bit_m"},   bus_m.bit_out,    0);
        chk({tag, "_valid_m"}, bus_m.bit_valid,  0);
        chk({tag, "_done_m"},  bus_m.word_done,  0);
        chk({tag, "_busy_m"},  bus_m.busy,       0);
        chk({tag, "_ready_m"}, bus_m.load_ready, 1);
        chk({tag, "_busy_l"},  bus_l.busy,       0);
        chk({tag, "_ready_l"}, bus_l.load_ready, 1);
    endtask

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic step();
        logic [7:0] cur;
        bit         ne;
        bit         m_ready;
        bit         m_adv;
        @(negedge clk);
        ne      = (wq.size() > 0);
        cur     = ne ? wq[0] : 8'h00;
        m_ready = (wq.size() < 2);
        m_adv   = ne && !hd;
        chk("ready_m", bus_m.load_ready, m_ready);
        chk("ready_l", bus_l.load_ready, m_ready);
        chk("bit_m",   bus_m.bit_out,    ne ? cur[7-pos] : 1'b0);
        chk("bit_l",   bus_l.bit_out,    ne ? cur[pos]   : 1'b0);
        chk("valid_m", bus_m.bit_valid,  m_adv);
        chk("valid_l", bus_l.bit_valid,  m_adv);
        chk("done_m",  bus_m.word_done,  m_adv && pos == 7);
        chk("done_l",  bus_l.word_done,  m_adv && pos == 7);
        chk("busy_m",  bus_m.busy,       ne);
        chk("busy_l",  bus_l.busy,       ne);
        if (bus_m.bit_valid) begin
            col_m = {col_m[62:0], bus_m.bit_out};
            ncol++;
        end
        if (bus_l.bit_valid) col_l = {col_l[62:0], bus_l.bit_out};
        if (bus_m.busy) nbusy++;
        if (bus_l.word_done) done_at = cyc;
        cyc++;
        @(posedge clk);
        acc = 1'b0;
        if (m_adv) begin
            pos++;
            if (pos == 8) begin
                void'(wq.pop_front());
                pos = 0;
            end
        end
        if (lv && m_ready) begin
            wq.push_back(ld);
            acc = 1'b1;
        end
        #1;
    endtask

    logic [7:0] w3 [3];
    int         k;

    initial begin
        rst = 1'b0; lv = 1'b0; hd = 1'b0; ld = '0;
        w3[0] = 8'hA5; w3[1] = 8'h3C; w3[2] = 8'hFF;
        #12;
        chk_reset_outs("rst0");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Single word 8'h99 from IDLE
        lv = 1'b1; ld = 8'h99;
        step();
        lv = 1'b0; clr();
        repeat (9) step();
        chk("t1_bits_m", col_m[7:0], 8'h99);
        chk("t1_bits_l", col_l[7:0], 8'h99);
        chk("t1_nbits",  ncol,       8);
        chk("t1_done",   done_at,    7);

        // Back-to-back words: 16 contiguous bits
        lv = 1'b1; ld = 8'h90;
        step();
        clr(); ld = 8'h09;
        step();
        chk("t2_acc2", acc, 1);
        lv = 1'b0;
        repeat (15) step();
        chk("t2_bits", col_m[15:0], 16'h9009);
        chk("t2_nbits", ncol, 16);
        repeat (2) step();

        // Three words offered continuously
        k = 0; clr();
        for (int i = 0; i < 30; i++) begin
            lv = (k < 3);
            ld = (k < 3) ? w3[k] : 8'h00;
            step();
            if (acc) k++;
        end
        lv = 1'b0;
        chk("t3_accepts", k, 3);
        chk("t3_bits", col_m[23:0], 24'hA53CFF);
        chk("t3_nbits", ncol, 24);
        chk("t3_busy_cycles", nbusy, 24);

        // Hold for 3 cycles after the 4th bit
        lv = 1'b1; ld = 8'h99;
        step();
        lv = 1'b0; clr();
        repeat (4) step();
        hd = 1'b1;
        repeat (3) begin
            #1;
            chk("t4_hold_bit", bus_m.bit_out, 1);
            chk("t4_hold_valid", bus_m.bit_valid, 0);
            step();
        end
        hd = 1'b0;
        repeat (5) step();
        chk("t4_bits", col_m[7:0], 8'h99);
        chk("t4_nbits", ncol, 8);
        chk("t4_done", done_at, 10);

        // Async reset mid-word with the buffer full
        lv = 1'b1; ld = 8'hC3;
        step();
        ld = 8'h5A;
        step();
        lv = 1'b0;
        repeat (2) step();
        chk("t5_busy_pre", bus_m.busy, 1);
        chk("t5_ready_pre", bus_m.load_ready, 0);
        #2 rst = 1'b0;
        #1;
        chk_reset_outs("t5_rst");
        wq.delete(); pos = 0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        clr();
        lv = 1'b1; ld = 8'h3C;
        step();
        lv = 1'b0;
        repeat (10) step();
        chk("t5_bits", col_m[7:0], 8'h3C);
        chk("t5_nbits", ncol, 8);

        // LSB-first instance, word 8'h01
        lv = 1'b1; ld = 8'h01;
        step();
        lv = 1'b0; clr();
        repeat (9) step();
        chk("t6_bits_l", col_l[7:0], 8'h80);
        chk("t6_done", done_at, 7);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            lv = 1'($urandom_range(0, 1));
            hd = ($urandom_range(0, 3) == 0);
            ld = 8'($urandom);
            step();
        end
        lv = 1'b0; hd = 1'b0;
        repeat (20) step();
        chk("drain_busy", bus_m.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ser_piso_stream.md
Name: ser_piso_stream

Overview:
- Parallel-in, serial-out word serializer that generates the one-bit-per-clock stream consumed by the codebase's serial sequence detectors (e.g. the 1001 Mealy detector's data_in).
- Accepts WIDTH-bit words over a valid/ready handshake and emits them bit by bit with a bit_valid qualifier.
- A one-deep holding buffer lets back-to-back words stream with no idle gap.
- Sits between a test-pattern/word source and the detector.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 emitted first; 0 = bit 0 emitted first.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- load_valid  input  1  source presents a word.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  block can accept a word this cycle.
- hold  input  1  freeze the stream; no bit consumed this cycle.
- bit_out  output  1  current serial bit; feeds the detector's data_in.
- bit_valid  output  1  bit_out is a real stream bit this cycle.
- word_done  output  1  the current bit is the last bit of its word.
- busy  output  1  a word is being shifted or is buffered.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; shift register, count and buffer are cleared.
  - Outputs: bit_out=0, bit_valid=0, word_done=0, busy=0, load_ready=1.
  - Any in-flight word and any buffered word are discarded. Deassertion is synchronous to clk.
- Handshake:
  - A word is accepted at a rising edge when load_valid=1 and load_ready=1.
  - load_ready = !buf_full, combinational from registered state only; it never depends on load_valid.
  - load_data is sampled only on accept.
- States: IDLE, SHIFT (2-bit encoding).
  - IDLE: bit_valid=0, bit_out=0.
    - On accept, load the word into the shift register, set count=WIDTH-1, go to SHIFT.
    - The first bit is on bit_out in the cycle after accept (latency 1).
  - SHIFT: bit_valid = !hold; bit_out = shift_reg[WIDTH-1] (shifting left) when MSB_FIRST=1, else shift_reg[0] (shifting right).
    - Each cycle with hold=0: shift one place and decrement count.
    - With hold=1: shift register and count do not change and bit_valid=0. Accepts into the buffer still occur.
  - Last bit (count==0, hold=0): word_done=1, combinational, same cycle as the bit. The next cycle is then decided as follows:
    - Buffer full: move the buffer into the shift register, count=WIDTH-1, stay in SHIFT, clear the buffer. This gives zero gap.
    - Buffer empty and an accept occurs the same cycle: load the incoming word directly into the shift register (bypass), stay in SHIFT.
    - Otherwise: go to IDLE.
  - SHIFT, not last bit: an accept writes the buffer and sets buf_full.
- Simultaneous events:
  - Last bit with buffer full: load_ready=0, so no accept is possible; the buffer drains into the shift register.
  - hold=1 on the last-bit cycle: word_done=0 and nothing advances; the last bit completes on the first cycle with hold=0.
- busy = (state==SHIFT) | buf_full.
- Stream ordering is strictly FIFO: words are emitted in accept order and bits are never dropped or duplicated.

Decomposition:
- Shared package/include: state encodings (S_IDLE=2'b00, S_SHIFT=2'b01) and a width-of-count helper (CNT_W = clog2(WIDTH)).
- No sub-module; the holding buffer is a single register plus flag, kept inline.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, load 8'h99 from IDLE.
   -> bit_out = 1,0,0,1,1,0,0,1 on the 8 cycles after accept; bit_valid=1 throughout; word_done only on the 8th; IDLE on the 9th.
2. Back-to-back 8'h90 then 8'h09, both offered immediately.
   -> 16 contiguous valid bits 1001_0000_0000_1001 with no bit_valid gap.
   -> load_ready=0 from the cycle after the second accept until word 1's last bit.
3. Three words offered continuously (8'hA5, 8'h3C, 8'hFF).
   -> The third is stalled until the first completes.
   -> Output is 24 bits in order; busy=1 for all 24 cycles, then 0.
4. 8'h99 with hold=1 for 3 cycles after the 4th bit.
   -> bit_valid=0 for those 3 cycles; bit_out holds bit 5 (1); the sequence resumes unaltered; word_done is delayed 3 cycles.
5. rst=0 asserted asynchronously mid-word (after 3 bits) with the buffer full.
   -> All outputs reach reset values immediately; load_ready=1; the next accept emits only the new word.
6. MSB_FIRST=0, load 8'h01.
   -> bit_out = 1,0,0,0,0,0,0,0; word_done on the 8th bit.
